// File: rtl/sd_ctrl_pkg.sv
// Shared constants and state encodings for the SD block reader.
package sd_ctrl_pkg;

    // SPI I/O block register map
    localparam logic [2:0] REG_DATA_HI = 3'd0;
    localparam logic [2:0] REG_DATA_LO = 3'd1;
    localparam logic [2:0] REG_CTRL    = 3'd2;
    localparam logic [2:0] REG_PRESC   = 3'd3;

    // CTRL values: SSM=1, 16B=0, SS=10 selects SS0; SS=11 releases all
    localparam logic [7:0] CTRL_SEL0  = 8'h22;
    localparam logic [7:0] CTRL_DESEL = 8'h23;

    localparam logic [7:0] CMD17       = 8'h51;
    localparam logic [7:0] TOKEN_START = 8'hFE;
    localparam logic [7:0] FILL        = 8'hFF;

    localparam logic [1:0] ERR_OK         = 2'd0;
    localparam logic [1:0] ERR_R1_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_R1_BAD     = 2'd2;
    localparam logic [1:0] ERR_TOKEN      = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SEL,
        ST_CMD,
        ST_R1,
        ST_TOKEN,
        ST_DATA,
        ST_CRC,
        ST_DESEL,
        ST_TRAIL,
        ST_DONE
    } rd_state_t;

    typedef enum logic [2:0] {
        XS_IDLE,
        XS_WRITE,
        XS_SETTLE,
        XS_POLL,
        XS_CHK,
        XS_READ,
        XS_CAP
    } xfer_state_t;

    // Byte idx of the 6-byte CMD17 frame (fixed dummy CRC byte last)
    function automatic logic [7:0] cmd_byte(input logic [31:0] arg, input logic [2:0] idx);
        case (idx)
            3'd0:    return CMD17;
            3'd1:    return arg[31:24];
            3'd2:    return arg[23:16];
            3'd3:    return arg[15:8];
            3'd4:    return arg[7:0];
            default: return FILL;
        endcase
    endfunction

endpackage

// File: rtl/spi_byte_xfer.sv
// One SPI byte exchange (or a raw CTRL write) through the SPI register block.
module spi_byte_xfer
    import sd_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       wr_only,
    input  logic [7:0] tx,
    output logic       ack,
    output logic [7:0] rx,
    output logic       spi_cs,
    output logic       spi_rw,
    output logic [2:0] spi_ad,
    output logic [7:0] spi_wdata,
    input  logic [7:0] spi_rdata
);

    localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    xfer_state_t   state, state_nxt;
    logic          wr_q, wr_nxt;
    logic [SW-1:0] cnt, cnt_nxt;
    logic          cs_nxt, rw_nxt, ack_nxt;
    logic [2:0]    ad_nxt;
    logic [7:0]    wdata_nxt, rx_nxt;

    // State and registered bus outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= XS_IDLE;
            wr_q      <= 1'b0;
            cnt       <= '0;
            ack       <= 1'b0;
            rx        <= 8'h00;
            spi_cs    <= 1'b0;
            spi_rw    <= 1'b1;
            spi_ad    <= 3'd0;
            spi_wdata <= 8'h00;
        end else begin
            state     <= state_nxt;
            wr_q      <= wr_nxt;
            cnt       <= cnt_nxt;
            ack       <= ack_nxt;
            rx        <= rx_nxt;
            spi_cs    <= cs_nxt;
            spi_rw    <= rw_nxt;
            spi_ad    <= ad_nxt;
            spi_wdata <= wdata_nxt;
        end
    end

    // Write, settle, poll RDY, read data
    always_comb begin
        state_nxt = state;
        case (state)
            XS_IDLE:   if (req) state_nxt = XS_WRITE;
            XS_WRITE:  state_nxt = wr_q ? XS_IDLE : XS_SETTLE;
            XS_SETTLE: if (cnt == SW'(SETTLE - 1)) state_nxt = XS_POLL;
            XS_POLL:   state_nxt = XS_CHK;
            XS_CHK:    state_nxt = spi_rdata[7] ? XS_READ : XS_POLL;
            XS_READ:   state_nxt = XS_CAP;
            XS_CAP:    state_nxt = XS_IDLE;
            default:   state_nxt = XS_IDLE;
        endcase
    end

    // Bus access decode from the next state; rx captured the cycle after the DATA_LO read
    always_comb begin
        cs_nxt    = 1'b0;
        rw_nxt    = 1'b1;
        ad_nxt    = spi_ad;
        wdata_nxt = spi_wdata;
        wr_nxt    = wr_q;
        cnt_nxt   = '0;
        ack_nxt   = 1'b0;
        rx_nxt    = rx;
        case (state_nxt)
            XS_WRITE: begin
                cs_nxt    = 1'b1;
                rw_nxt    = 1'b0;
                ad_nxt    = wr_only ? REG_CTRL : REG_DATA_LO;
                wdata_nxt = tx;
                wr_nxt    = wr_only;
            end
            XS_POLL: begin
                cs_nxt = 1'b1;
                ad_nxt = REG_CTRL;
            end
            XS_READ: begin
                cs_nxt = 1'b1;
                ad_nxt = REG_DATA_LO;
            end
            default: ;
        endcase
        if (state == XS_SETTLE)
            cnt_nxt = cnt + SW'(1);
        if (state == XS_CAP) begin
            ack_nxt = 1'b1;
            rx_nxt  = spi_rdata;
        end
        if (state == XS_WRITE && wr_q)
            ack_nxt = 1'b1;
    end

endmodule

// File: rtl/sd_block_reader.sv
// CMD17 single-block reader: drives the SPI register block and fills the buffer RAM.
module sd_block_reader #(
    parameter int unsigned R1_TIMEOUT    = 8,
    parameter int unsigned TOKEN_TIMEOUT = 4096,
    parameter int unsigned SETTLE        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] lba,
    input  logic        sdhc,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err_code,
    output logic        mem_we,
    output logic [8:0]  mem_addr,
    output logic [7:0]  mem_data,
    output logic        spi_cs,
    output logic        spi_rw,
    output logic [2:0]  spi_ad,
    output logic [7:0]  spi_wdata,
    input  logic [7:0]  spi_rdata
);
    import sd_ctrl_pkg::*;

    localparam int unsigned CW = 16;

    rd_state_t   state, state_nxt;
    logic [31:0] arg, arg_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic        pend, pend_nxt;
    logic        busy_nxt, done_nxt, mem_we_nxt;
    logic [1:0]  err_nxt;
    logic [8:0]  mem_addr_nxt;
    logic [7:0]  mem_data_nxt;
    logic        req_c, wr_only_c;
    logic [7:0]  tx_c;
    logic        x_ack;
    logic [7:0]  x_rx;

    spi_byte_xfer #(.SETTLE(SETTLE)) u_xfer (
        .clk       (clk),
        .rst       (rst),
        .req       (req_c),
        .wr_only   (wr_only_c),
        .tx        (tx_c),
        .ack       (x_ack),
        .rx        (x_rx),
        .spi_cs    (spi_cs),
        .spi_rw    (spi_rw),
        .spi_ad    (spi_ad),
        .spi_wdata (spi_wdata),
        .spi_rdata (spi_rdata)
    );

    // State register plus registered outputs and datapath
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            arg      <= 32'h0;
            cnt      <= '0;
            pend     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err_code <= ERR_OK;
            mem_we   <= 1'b0;
            mem_addr <= 9'd0;
            mem_data <= 8'h00;
        end else begin
            state    <= state_nxt;
            arg      <= arg_nxt;
            cnt      <= cnt_nxt;
            pend     <= pend_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            err_code <= err_nxt;
            mem_we   <= mem_we_nxt;
            mem_addr <= mem_addr_nxt;
            mem_data <= mem_data_nxt;
        end
    end

    // Sequence through select, command, response, token, data, CRC, deselect
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_SEL;
            ST_SEL:   if (x_ack) state_nxt = ST_CMD;
            ST_CMD:   if (x_ack && cnt == CW'(5)) state_nxt = ST_R1;
            ST_R1: if (x_ack) begin
                if (x_rx != FILL)
                    state_nxt = (x_rx == 8'h00) ? ST_TOKEN : ST_DESEL;
                else if (cnt == CW'(R1_TIMEOUT - 1))
                    state_nxt = ST_DESEL;
            end
            ST_TOKEN: if (x_ack) begin
                if (x_rx != FILL)
                    state_nxt = (x_rx == TOKEN_START) ? ST_DATA : ST_DESEL;
                else if (cnt == CW'(TOKEN_TIMEOUT - 1))
                    state_nxt = ST_DESEL;
            end
            ST_DATA:  if (x_ack && mem_addr == 9'd511) state_nxt = ST_CRC;
            ST_CRC:   if (x_ack && cnt == CW'(1)) state_nxt = ST_DESEL;
            ST_DESEL: if (x_ack) state_nxt = ST_TRAIL;
            ST_TRAIL: if (x_ack) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Exchange requests, counters, error capture and buffer writes
    always_comb begin
        req_c        = 1'b0;
        wr_only_c    = 1'b0;
        tx_c         = FILL;
        pend_nxt     = pend;
        cnt_nxt      = cnt;
        arg_nxt      = arg;
        err_nxt      = err_code;
        mem_we_nxt   = 1'b0;
        mem_data_nxt = mem_data;
        mem_addr_nxt = mem_we ? mem_addr + 9'd1 : mem_addr;
        busy_nxt     = !(state_nxt == ST_IDLE || state_nxt == ST_DONE);
        done_nxt     = (state_nxt == ST_DONE);

        if (state != ST_IDLE && state != ST_DONE)
            req_c = !pend;
        wr_only_c = (state == ST_SEL || state == ST_DESEL);
        case (state)
            ST_SEL:   tx_c = CTRL_SEL0;
            ST_DESEL: tx_c = CTRL_DESEL;
            ST_CMD:   tx_c = cmd_byte(arg, cnt[2:0]);
            default:  tx_c = FILL;
        endcase

        if (req_c)
            pend_nxt = 1'b1;
        else if (x_ack)
            pend_nxt = 1'b0;

        if (state_nxt != state)
            cnt_nxt = '0;
        else if (x_ack)
            cnt_nxt = cnt + CW'(1);

        if (state == ST_IDLE && start) begin
            arg_nxt      = sdhc ? lba : {lba[22:0], 9'b0};
            err_nxt      = ERR_OK;
            mem_addr_nxt = 9'd0;
        end

        if (state == ST_R1 && state_nxt == ST_DESEL)
            err_nxt = (x_rx == FILL) ? ERR_R1_TIMEOUT : ERR_R1_BAD;
        if (state == ST_TOKEN && state_nxt == ST_DESEL)
            err_nxt = ERR_TOKEN;

        if (state == ST_DATA && x_ack) begin
            mem_we_nxt   = 1'b1;
            mem_data_nxt = x_rx;
        end
    end

endmodule

// File: tb/tb_sd_block_reader.sv
// Directed bench for sd_block_reader with a behavioural SPI register block and SD card.
module tb_sd_block_reader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] lba;
    logic        sdhc;
    logic        busy, done;
    logic [1:0]  err_code;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [7:0]  mem_data;
    logic        spi_cs, spi_rw;
    logic [2:0]  spi_ad;
    logic [7:0]  spi_wdata;
    logic [7:0]  spi_rdata = 8'h00;

    sd_block_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .lba       (lba),
        .sdhc      (sdhc),
        .busy      (busy),
        .done      (done),
        .err_code  (err_code),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .spi_cs    (spi_cs),
        .spi_rw    (spi_rw),
        .spi_ad    (spi_ad),
        .spi_wdata (spi_wdata),
        .spi_rdata (spi_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] lba;
        logic        sdhc;
        int          r1_fills;
        logic [7:0]  r1_val;
        bit          r1_never;
        int          tok_fills;
        logic [7:0]  tok_val;
        logic [1:0]  exp_err;
        logic [47:0] exp_cmd;
        int          exp_mem;
        int          exp_ex;
        bit          start_on_done;
        bit          dup_start;
    } vec_t;

    // Card scenario (written by the test, read by the model)
    int         sc_r1_fills, sc_tok_fills;
    logic [7:0] sc_r1_val, sc_tok_val;
    bit         sc_never;

    // Monitor state
    bit          mon_clr = 1'b0;
    int          busy_cnt = 0;
    logic [7:0]  cur_rx = 8'hFF;
    int          ex_n = 0;
    int          ex_after_desel = 0;
    bit          desel_seen = 1'b0;
    logic [47:0] cmd_bytes = '0;
    logic [7:0]  ctrl_log[$];
    int          mem_cnt = 0, wr_idx = 0, data_bad = 0, done_cnt = 0, bad_access = 0;
    bit          prev_cs = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    function automatic logic [7:0] model_rx(input int kk);
        int k;
        k = kk;
        if (k < 6) return 8'hFF;
        k = k - 6;
        if (sc_never) return 8'hFF;
        if (k < sc_r1_fills) return 8'hFF;
        if (k == sc_r1_fills) return sc_r1_val;
        k = k - (sc_r1_fills + 1);
        if (k < sc_tok_fills) return 8'hFF;
        if (k == sc_tok_fills) return sc_tok_val;
        k = k - (sc_tok_fills + 1);
        if (k < 512) return 8'(k);
        return 8'hFF;
    endfunction

    // SPI register block + card model and bus/buffer monitor
    always @(negedge clk) begin
        if (mon_clr) begin
            ctrl_log.delete();
            cmd_bytes  = '0;
            mem_cnt    = 0;
            wr_idx     = 0;
            data_bad   = 0;
            done_cnt   = 0;
            bad_access = 0;
        end
        if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
        if (spi_cs && prev_cs) bad_access = bad_access + 1;
        prev_cs = spi_cs;
        if (spi_cs) begin
            if (!spi_rw) begin
                if (spi_ad == 3'd2) begin
                    ctrl_log.push_back(spi_wdata);
                    if (spi_wdata == 8'h22) begin
                        ex_n = 0;
                        ex_after_desel = 0;
                        desel_seen = 1'b0;
                    end
                    if (spi_wdata == 8'h23) desel_seen = 1'b1;
                end else if (spi_ad == 3'd1) begin
                    if (ex_n < 6) cmd_bytes = {cmd_bytes[39:0], spi_wdata};
                    cur_rx = model_rx(ex_n);
                    ex_n = ex_n + 1;
                    if (desel_seen) ex_after_desel = ex_after_desel + 1;
                    busy_cnt = 6;
                end else begin
                    bad_access = bad_access + 1;
                end
            end else begin
                if (spi_ad == 3'd2) spi_rdata = {(busy_cnt == 0), 7'd0};
                else if (spi_ad == 3'd1) spi_rdata = cur_rx;
                else bad_access = bad_access + 1;
            end
        end
        if (mem_we) begin
            if (mem_addr != wr_idx[8:0] || mem_data != mem_addr[7:0])
                data_bad = data_bad + 1;
            wr_idx  = wr_idx + 1;
            mem_cnt = mem_cnt + 1;
        end
        if (done) done_cnt = done_cnt + 1;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_mon();
        @(posedge clk);
        mon_clr = 1'b1;
        @(posedge clk);
        mon_clr = 1'b0;
    endtask

    task automatic set_scn(input vec_t v);
        sc_r1_fills  = v.r1_fills;
        sc_r1_val    = v.r1_val;
        sc_never     = v.r1_never;
        sc_tok_fills = v.tok_fills;
        sc_tok_val   = v.tok_val;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        bit seen;
        bit dup_done;
        logic [7:0] c0, c1;
        set_scn(v);
        clear_mon();
        @(negedge clk);
        lba   = v.lba;
        sdhc  = v.sdhc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lba   = ~v.lba;
        sdhc  = ~v.sdhc;
        check({nm, " busy after start"}, 64'(busy), 64'd1);
        seen = 1'b0;
        dup_done = 1'b0;
        for (int c = 0; c < 20000 && !seen; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (v.dup_start && !dup_done && mem_cnt >= 100) begin
                start = 1'b1;
                dup_done = 1'b1;
            end
            if (done) begin
                seen = 1'b1;
                if (v.start_on_done) start = 1'b1;
            end
        end
        check({nm, " done seen"}, 64'(seen), 64'd1);
        @(negedge clk);
        start = 1'b0;
        if (v.start_on_done) begin
            repeat (3) @(negedge clk);
            check({nm, " start on done ignored"}, 64'(busy), 64'd0);
        end
        repeat (30) @(negedge clk);
        c0 = (ctrl_log.size() > 0) ? ctrl_log[0] : 8'h00;
        c1 = (ctrl_log.size() > 1) ? ctrl_log[1] : 8'h00;
        check({nm, " err_code"},      64'(err_code),       64'(v.exp_err));
        check({nm, " done count"},    64'(done_cnt),       64'd1);
        check({nm, " mem_we count"},  64'(mem_cnt),        64'(v.exp_mem));
        check({nm, " mem data/addr"}, 64'(data_bad),       64'd0);
        check({nm, " cmd bytes"},     64'(cmd_bytes),      64'(v.exp_cmd));
        check({nm, " ctrl writes"},   64'(ctrl_log.size()), 64'd2);
        check({nm, " ctrl sel"},      64'(c0),             64'h22);
        check({nm, " ctrl desel"},    64'(c1),             64'h23);
        check({nm, " exchanges"},     64'(ex_n),           64'(v.exp_ex));
        check({nm, " trailer"},       64'(ex_after_desel), 64'd1);
        check({nm, " busy idle"},     64'(busy),           64'd0);
        check({nm, " mem_addr wrap"}, 64'(mem_addr),       64'd0);
        check({nm, " access spacing"}, 64'(bad_access),    64'd0);
    endtask

    vec_t vecs[7];

    initial begin
        bit hit;
        vecs[0] = '{32'h0000_0003, 1'b0, 2, 8'h00, 1'b0, 10, 8'hFE, 2'd0, 48'h51_00_00_06_00_FF, 512, 535, 1'b0, 1'b0};
        vecs[1] = '{32'h1234_5678, 1'b1, 2, 8'h00, 1'b0, 10, 8'hFE, 2'd0, 48'h51_12_34_56_78_FF, 512, 535, 1'b0, 1'b0};
        vecs[2] = '{32'h0000_0000, 1'b0, 0, 8'h00, 1'b1, 0,  8'hFE, 2'd1, 48'h51_00_00_00_00_FF, 0,   15,  1'b0, 1'b0};
        vecs[3] = '{32'h0000_0001, 1'b1, 0, 8'h00, 1'b0, 3,  8'hFC, 2'd3, 48'h51_00_00_00_01_FF, 0,   12,  1'b0, 1'b0};
        vecs[4] = '{32'h0040_0000, 1'b0, 1, 8'h05, 1'b0, 0,  8'hFE, 2'd2, 48'h51_80_00_00_00_FF, 0,   9,   1'b1, 1'b0};
        vecs[5] = '{32'h0000_0007, 1'b0, 2, 8'h00, 1'b0, 10, 8'hFE, 2'd0, 48'h51_00_00_0E_00_FF, 512, 535, 1'b0, 1'b1};
        vecs[6] = '{32'hFFFF_FFFF, 1'b0, 0, 8'h00, 1'b0, 0,  8'hFE, 2'd0, 48'h51_FF_FF_FE_00_FF, 512, 523, 1'b0, 1'b0};

        rst   = 1'b0;
        start = 1'b0;
        lba   = 32'h0;
        sdhc  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy",     64'(busy),     64'd0);
        check("reset done",     64'(done),     64'd0);
        check("reset mem_we",   64'(mem_we),   64'd0);
        check("reset spi_cs",   64'(spi_cs),   64'd0);
        check("reset spi_rw",   64'(spi_rw),   64'd1);
        check("reset err_code", 64'(err_code), 64'd0);
        check("reset mem_addr", 64'(mem_addr), 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of the data phase
        set_scn(vecs[0]);
        clear_mon();
        @(negedge clk);
        lba   = 32'h0000_0003;
        sdhc  = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 20000 && !hit; c++) begin
            @(negedge clk);
            if (mem_cnt >= 200) hit = 1'b1;
        end
        check("midrst reached byte 200", 64'(hit), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst busy",   64'(busy),   64'd0);
        check("midrst spi_cs", 64'(spi_cs), 64'd0);
        check("midrst mem_we", 64'(mem_we), 64'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst stays idle", 64'(busy), 64'd0);
        run_vec(vecs[0], "after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
